// File: rtl/exec_sequencer.sv
// Programmable (F, R) command sequencer: queues commands and on a Run rise drives
// WIDTH Shift_En cycles per command. Define SEQ_RETAIN_EN to keep the queue as a replayable program.
module exec_sequencer #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH),
  localparam int SW    = $clog2(WIDTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          LoadA,
  input  logic          LoadB,
  input  logic          Run,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd_F,
  input  logic [1:0]    cmd_R,
  input  logic          cmd_clear,
  output logic          cmd_ready,
  output logic          Ld_A,
  output logic          Ld_B,
  output logic          Shift_En,
  output logic [2:0]    F_out,
  output logic [1:0]    R_out,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_NEXT, S_DONE} state_e;

  state_e        state_q;
  logic [2:0]    mem_f [DEPTH];
  logic [1:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, nxt_ptr;
  logic [CW-1:0] count_q;
  logic [SW-1:0] shcnt_q;
  logic          loada_q, loadb_q, run_q, armed_q;
  logic          ld_a_q, ld_b_q, shift_en_q, busy_q, done_q;
  logic [2:0]    f_out_q;
  logic [1:0]    r_out_q;
  logic          is_idle, clear, push, pop;
  logic          loada_rise, loadb_rise, run_rise;
`ifdef SEQ_RETAIN_EN
  logic [CW-1:0] idx_q;
`endif

  // armed_q masks the first edge after reset so levels held through release never read as rises.
  assign loada_rise = LoadA & ~loada_q & armed_q;
  assign loadb_rise = LoadB & ~loadb_q & armed_q;
  assign run_rise   = Run   & ~run_q   & armed_q;

  assign is_idle = (state_q == S_IDLE);
  assign clear   = is_idle & cmd_clear;
`ifdef SEQ_RETAIN_EN
  assign cmd_ready = (count_q != CW'(DEPTH)) & is_idle;
  assign pop       = 1'b0;
  assign nxt_ptr   = rd_ptr_q + idx_q[PW-1:0] + PW'(1);
`else
  assign cmd_ready = (count_q != CW'(DEPTH));
  assign pop       = (state_q == S_NEXT);
  assign nxt_ptr   = rd_ptr_q + PW'(1);
`endif
  assign push = cmd_valid & cmd_ready & ~clear;

  // NOTE: queue storage has no reset; count_q and the pointers alone decide which entries are valid.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_f[wr_ptr_q] <= cmd_F;
      mem_r[wr_ptr_q] <= cmd_R;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shcnt_q    <= '0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      run_q      <= 1'b0;
      armed_q    <= 1'b0;
      ld_a_q     <= 1'b0;
      ld_b_q     <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      f_out_q    <= '0;
      r_out_q    <= '0;
`ifdef SEQ_RETAIN_EN
      idx_q      <= '0;
`endif
    end else begin
      loada_q <= LoadA;
      loadb_q <= LoadB;
      run_q   <= Run;
      armed_q <= 1'b1;
      ld_a_q  <= 1'b0;
      ld_b_q  <= 1'b0;
      done_q  <= 1'b0;

      if (clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end

      case (state_q)
        S_IDLE: begin
          ld_a_q <= loada_rise;
          ld_b_q <= loadb_rise;
          if (run_rise && (count_q != '0) && !cmd_clear) begin
            state_q    <= S_SHIFT;
            shift_en_q <= 1'b1;
            busy_q     <= 1'b1;
            shcnt_q    <= SW'(WIDTH - 1);
            f_out_q    <= mem_f[rd_ptr_q];
            r_out_q    <= mem_r[rd_ptr_q];
          end
        end
        S_SHIFT: begin
          if (shcnt_q == '0) begin
            state_q    <= S_NEXT;
            shift_en_q <= 1'b0;
          end else begin
            shcnt_q <= shcnt_q - SW'(1);
          end
        end
        S_NEXT: begin
`ifdef SEQ_RETAIN_EN
          if (idx_q + CW'(1) < count_q) begin
            idx_q <= idx_q + CW'(1);
`else
          if (count_q > CW'(1)) begin
`endif
            state_q    <= S_SHIFT;
            shift_en_q <= 1'b1;
            shcnt_q    <= SW'(WIDTH - 1);
            f_out_q    <= mem_f[nxt_ptr];
            r_out_q    <= mem_r[nxt_ptr];
          end else begin
`ifdef SEQ_RETAIN_EN
            idx_q <= '0;
`endif
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Ld_A     = ld_a_q;
  assign Ld_B     = ld_b_q;
  assign Shift_En = shift_en_q;
  assign F_out    = f_out_q;
  assign R_out    = r_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a queue of pushed commands is the scoreboard,
// popped (or indexed, with SEQ_RETAIN_EN) as each Shift_En run starts.
module tb_exec_sequencer;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          LoadA = 1'b0, LoadB = 1'b0, Run = 1'b0;
  logic          cmd_valid = 1'b0, cmd_clear = 1'b0;
  logic [2:0]    cmd_F = '0;
  logic [1:0]    cmd_R = '0;
  logic          cmd_ready, Ld_A, Ld_B, Shift_En, busy, done;
  logic [2:0]    F_out;
  logic [1:0]    R_out;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [2:0] f;
    logic [1:0] r;
  } cmd_t;

  cmd_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  exec_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB), .Run(Run),
    .cmd_valid(cmd_valid), .cmd_F(cmd_F), .cmd_R(cmd_R), .cmd_clear(cmd_clear),
    .cmd_ready(cmd_ready), .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En),
    .F_out(F_out), .R_out(R_out), .busy(busy), .done(done), .count(count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] f, input logic [1:0] r);
    logic exp_ready;
    exp_ready = (exp_q.size() != DEPTH);
    check("cmd_ready_before_push", cmd_ready, exp_ready);
    cmd_valid = 1'b1;
    cmd_F     = f;
    cmd_R     = r;
    step();
    cmd_valid = 1'b0;
    if (exp_ready) exp_q.push_back({f, r});
    check("count_after_push", count, exp_q.size());
  endtask

  // Raises Run and checks every cycle of an n-command sequence; poke injects ignored requests mid-run.
  task automatic run_seq(input int n, input bit poke);
    int   total;
    int   pos;
    int   r;
    cmd_t cur;
    total = n * (WIDTH + 1);
    cur   = '0;
    Run   = 1'b1;
    for (int m = 1; m <= total + 2; m++) begin
      step();
      pos = (m - 1) % (WIDTH + 1);
      r   = (m - 1) / (WIDTH + 1);
      if (m <= total && pos == 0) begin
`ifdef SEQ_RETAIN_EN
        cur = exp_q[r];
`else
        cur = exp_q.pop_front();
`endif
      end
      check("shift_en", Shift_En, (m <= total) && (pos < WIDTH));
      check("busy", busy, m <= total);
      check("done", done, m == total + 1);
      check("ld_a_in_seq", Ld_A, 1'b0);
      if (m <= total && pos < WIDTH) begin
        check("f_out", F_out, cur.f);
        check("r_out", R_out, cur.r);
      end
      if (m == 1) Run = 1'b0;
      if (poke && m == 4) begin
        Run       = 1'b1;
        LoadA     = 1'b1;
        cmd_clear = 1'b1;
      end
      if (m == 5) cmd_clear = 1'b0;
    end
    Run   = 1'b0;
    LoadA = 1'b0;
    check("count_after_seq", count, exp_q.size());
  endtask

  initial begin
    // Reset held with LoadA/Run high; release must not create rises.
    LoadA = 1'b1;
    Run   = 1'b1;
    repeat (2) step();
    check("rst_shift_en", Shift_En, 1'b0);
    check("rst_ld_a", Ld_A, 1'b0);
    check("rst_ld_b", Ld_B, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_f_out", F_out, 3'd0);
    check("rst_r_out", R_out, 2'd0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_count", count, 0);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("held_ld_a", Ld_A, 1'b0);
      check("held_busy", busy, 1'b0);
    end
    LoadA = 1'b0;
    Run   = 1'b0;
    step();

    // Two commands executed back to back.
    push_cmd(3'b000, 2'b00);
    push_cmd(3'b010, 2'b01);
    run_seq(2, 1'b0);
`ifdef SEQ_RETAIN_EN
    run_seq(2, 1'b0);
    cmd_clear = 1'b1;
    step();
    cmd_clear = 1'b0;
    exp_q.delete();
    check("count_after_clear", count, 0);
`endif

    // Simultaneous LoadA/LoadB rises in IDLE.
    LoadA = 1'b1;
    LoadB = 1'b1;
    step();
    check("ld_a_pulse", Ld_A, 1'b1);
    check("ld_b_pulse", Ld_B, 1'b1);
    step();
    check("ld_a_one_cycle", Ld_A, 1'b0);
    check("ld_b_one_cycle", Ld_B, 1'b0);
    LoadA = 1'b0;
    LoadB = 1'b0;
    step();

    // Fill the queue (pointers wrap), 5th push dropped, then run with ignored mid-run requests.
    push_cmd(3'b101, 2'b10);
    push_cmd(3'b111, 2'b11);
    push_cmd(3'b001, 2'b01);
    push_cmd(3'b110, 2'b10);
    check("full_cmd_ready", cmd_ready, 1'b0);
    push_cmd(3'b011, 2'b11);
    run_seq(4, 1'b1);
    cmd_clear = 1'b1;
    step();
    cmd_clear = 1'b0;
    exp_q.delete();
    check("count_cleared", count, 0);

    // Run with an empty queue does nothing.
    Run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("empty_run_busy", busy, 1'b0);
      check("empty_run_done", done, 1'b0);
      check("empty_run_shift", Shift_En, 1'b0);
    end
    Run = 1'b0;
    step();

    // Clear wins over a simultaneous push.
    push_cmd(3'b100, 2'b01);
    cmd_valid = 1'b1;
    cmd_clear = 1'b1;
    cmd_F     = 3'b111;
    step();
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
    exp_q.delete();
    check("clear_beats_push", count, 0);
    check("ready_after_clear", cmd_ready, 1'b1);

    // Asynchronous reset in the middle of a shift run.
    push_cmd(3'b011, 2'b10);
    push_cmd(3'b110, 2'b01);
    Run = 1'b1;
    repeat (3) step();
    Run = 1'b0;
    check("mid_shift_active", Shift_En, 1'b1);
    Reset = 1'b1;
    #1;
    check("async_rst_shift_en", Shift_En, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_count", count, 0);
    check("async_rst_ready", cmd_ready, 1'b1);
    check("async_rst_f_out", F_out, 3'd0);
    exp_q.delete();
    step();
    Reset = 1'b0;
    step();
    check("post_rst_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
